// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the PS/2 pins, decodes 11-bit frames and
// queues good bytes in a first-word-fall-through FIFO with sticky error flags.
module ps2_rx_fifo #(
  parameter int DEPTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                       CLOCK_50,
  input  logic                       Resetn,
  input  logic                       PS2_CLK,
  input  logic                       PS2_DAT,
  input  logic                       rd_en,
  input  logic                       clear_err,
  output logic [7:0]                 rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES-1);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] r_clkSync;
  logic [SYNC_STAGES-1:0] r_datSync;
  logic                   r_clkPrev;
  state_t                 r_state;
  logic [2:0]             r_bitCnt;
  logic [7:0]             r_shift;
  logic                   r_parity;
  logic [TW-1:0]          r_timeout;
  logic                   r_parityErr;
  logic                   r_frameErr;
  logic                   r_overflow;
  logic [7:0]             r_mem [DEPTH];
  logic [AW-1:0]          r_wrPtr;
  logic [AW-1:0]          r_rdPtr;
  logic [CW-1:0]          r_count;

  logic w_clkS;
  logic w_datS;
  logic w_fe;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_doPush;
  logic w_ovfSet;

  // Synchronisers idle high so reset never fabricates a falling edge.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      r_clkSync <= '1;
      r_datSync <= '1;
      r_clkPrev <= 1'b1;
    end else begin
      r_clkSync <= {r_clkSync[SYNC_STAGES-2:0], PS2_CLK};
      r_datSync <= {r_datSync[SYNC_STAGES-2:0], PS2_DAT};
      r_clkPrev <= w_clkS;
    end
  end

  assign w_clkS   = r_clkSync[SYNC_STAGES-1];
  assign w_datS   = r_datSync[SYNC_STAGES-1];
  assign w_fe     = r_clkPrev & ~w_clkS;
  assign w_full   = (r_count == FULL_COUNT);
  assign w_pop    = rd_en & rd_valid;
  assign w_push   = (r_state == STOP) & w_fe & w_datS & (^{r_shift, r_parity});
  assign w_doPush = w_push & (~w_full | w_pop);
  assign w_ovfSet = w_push & w_full & ~w_pop;

  // Frame decoder; sets placed after the clear so a simultaneous set wins.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      r_state     <= IDLE;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_timeout   <= '0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (clear_err) begin
        r_parityErr <= 1'b0;
        r_frameErr  <= 1'b0;
        r_overflow  <= 1'b0;
      end
      if (w_ovfSet) r_overflow <= 1'b1;

      if (r_state == IDLE) begin
        r_timeout <= '0;
        if (w_fe && !w_datS) begin
          r_state  <= DATA;
          r_bitCnt <= '0;
        end
      end else if (w_fe) begin
        r_timeout <= '0;
        case (r_state)
          DATA: begin
            r_shift  <= {w_datS, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_parity <= w_datS;
            r_state  <= STOP;
          end
          default: begin
            if (!w_datS) r_frameErr <= 1'b1;
            else if (~^{r_shift, r_parity}) r_parityErr <= 1'b1;
            r_state <= IDLE;
          end
        endcase
      end else if (r_timeout == TIMEOUT_MAX) begin
        r_frameErr <= 1'b1;
        r_state    <= IDLE;
        r_timeout  <= '0;
      end else begin
        r_timeout <= r_timeout + TW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_doPush) r_mem[r_wrPtr] <= r_shift;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)    r_rdPtr <= r_rdPtr + AW'(1);
      if (w_doPush && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_doPush) r_count <= r_count - CW'(1);
    end
  end

  assign rd_data    = r_mem[r_rdPtr];
  assign rd_valid   = (r_count != '0);
  assign count      = r_count;
  assign parity_err = r_parityErr;
  assign frame_err  = r_frameErr;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: drives PS/2 frames and compares the FIFO and flags
// against a frame-level queue model.
module tb_ps2_rx_fifo;

  localparam int DEPTH   = 4;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 5000;
  localparam int CW      = $clog2(DEPTH+1);

  logic          CLOCK_50 = 1'b0;
  logic          Resetn;
  logic          PS2_CLK;
  logic          PS2_DAT;
  logic          rd_en;
  logic          clear_err;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;

  int testsRun  = 0;
  int failCount = 0;

  logic [7:0] q[$];
  logic       mPar;
  logic       mFrm;
  logic       mOvf;
  logic [7:0] tmp;

  ps2_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .rd_en(rd_en), .clear_err(clear_err), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #(99000 * 20);
    $display("[TB] FAIL watchdog: simulation ran past its cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  function automatic logic oddPar(input logic [7:0] d);
    return ~^d;
  endfunction

  // Frame-level reference: stop bit first, then parity, then capacity.
  task automatic modelFrame(input logic [7:0] d, input logic par, input logic stop);
    if (!stop) mFrm = 1'b1;
    else if (((^d) ^ par) == 1'b0) mPar = 1'b1;
    else if (q.size() >= DEPTH) mOvf = 1'b1;
    else q.push_back(d);
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".count"}, 32'(count), 32'(q.size()));
    checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
    if (q.size() != 0) checkOutput({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
    checkOutput({tag, ".parity_err"}, 32'(parity_err), 32'(mPar));
    checkOutput({tag, ".frame_err"}, 32'(frame_err), 32'(mFrm));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(mOvf));
  endtask

  // Sends the first nBits bits of a frame; optionally pops exactly on the stop-bit fe cycle.
  task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stop,
                               input int nBits, input int half, input bit popAtStop);
    logic [10:0] frame;
    frame = {stop, par, d, 1'b0};
    for (int b = 0; b < nBits; b++) begin
      PS2_DAT = frame[b];
      waitCycles(half);
      PS2_CLK = 1'b0;
      for (int c = 0; c < half; c++) begin
        @(posedge CLOCK_50);
        #1;
        rd_en = 1'b0;
        if (popAtStop && b == 10 && c == SYNC - 1) begin
          checkOutput("popPushHead", 32'(rd_data), 32'(q[0]));
          tmp = q.pop_front();
          rd_en = 1'b1;
        end
      end
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    waitCycles(4);
  endtask

  task automatic runFrame(input string tag, input logic [7:0] d, input logic par,
                          input logic stop, input int half, input bit popAtStop);
    applyStimulus(d, par, stop, 11, half, popAtStop);
    modelFrame(d, par, stop);
    checkState(tag);
  endtask

  task automatic popOne(input string tag);
    checkOutput({tag, ".head"}, 32'(rd_data), 32'(q[0]));
    rd_en = 1'b1;
    waitCycles(1);
    rd_en = 1'b0;
    tmp = q.pop_front();
    checkState(tag);
  endtask

  task automatic clearErr(input string tag);
    clear_err = 1'b1;
    waitCycles(1);
    clear_err = 1'b0;
    mPar = 1'b0;
    mFrm = 1'b0;
    mOvf = 1'b0;
    checkState(tag);
  endtask

  initial begin
    Resetn = 1'b0; PS2_CLK = 1'b1; PS2_DAT = 1'b1; rd_en = 1'b0; clear_err = 1'b0;
    mPar = 1'b0; mFrm = 1'b0; mOvf = 1'b0;
    waitCycles(3);
    Resetn = 1'b1;
    waitCycles(2);
    checkState("reset");

    runFrame("good1C", 8'h1C, 1'b0, 1'b1, 1000, 1'b0);
    popOne("pop1C");

    runFrame("seqF0", 8'hF0, 1'b1, 1'b1, 40, 1'b0);
    runFrame("seq1C", 8'h1C, 1'b0, 1'b1, 40, 1'b0);
    popOne("popF0");
    popOne("pop1C2");

    runFrame("badPar", 8'h1C, 1'b1, 1'b1, 40, 1'b0);
    clearErr("clrPar");

    runFrame("badStop", 8'h5A, oddPar(8'h5A), 1'b0, 40, 1'b0);
    clearErr("clrStop");

    // Start bit plus five data bits, then the clock stays high.
    applyStimulus(8'h29, 1'b0, 1'b1, 6, 40, 1'b0);
    waitCycles(TIMEOUT - 20 - 44);
    checkOutput("timeoutEarly", 32'(frame_err), 32'd0);
    waitCycles(40);
    mFrm = 1'b1;
    checkState("timeout");
    runFrame("after29", 8'h29, oddPar(8'h29), 1'b1, 40, 1'b0);
    popOne("pop29");
    clearErr("clrTimeout");

    for (int i = 1; i <= 5; i++)
      runFrame("fill", 8'(i), oddPar(8'(i)), 1'b1, 25, 1'b0);
    for (int i = 0; i < 4; i++) popOne("drain");
    clearErr("clrOvf");

    for (int i = 1; i <= 4; i++)
      runFrame("fill2", 8'(8'h10 + i), oddPar(8'(8'h10 + i)), 1'b1, 25, 1'b0);
    runFrame("pushPop", 8'h15, oddPar(8'h15), 1'b1, 25, 1'b1);
    for (int i = 0; i < 4; i++) popOne("drain2");

    applyStimulus(8'h33, oddPar(8'h33), 1'b1, 5, 40, 1'b0);
    Resetn = 1'b0;
    waitCycles(2);
    Resetn = 1'b1;
    q.delete();
    mPar = 1'b0; mFrm = 1'b0; mOvf = 1'b0;
    waitCycles(2);
    checkState("midReset");
    runFrame("after44", 8'h44, oddPar(8'h44), 1'b1, 40, 1'b0);
    popOne("pop44");

    for (int i = 0; i < 14; i++) begin
      logic [7:0] d;
      int kind;
      d = 8'($urandom);
      kind = $urandom_range(0, 9);
      runFrame("rand", d, (kind == 0) ? ~oddPar(d) : oddPar(d), (kind == 1) ? 1'b0 : 1'b1,
               $urandom_range(20, 50), 1'b0);
      if (q.size() != 0 && $urandom_range(0, 2) == 0) popOne("randPop");
      if ($urandom_range(0, 3) == 0) clearErr("randClr");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
